// File: rtl/mux_rr_sequencer_pkg.sv
// Shared constants, FSM state type and helpers for the round-robin mux sequencer.
package mux_seq_pkg;

  localparam int NCH  = 8;
  localparam int SELW = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    PRESENT = 2'd2
  } state_t;

  // One-hot channel mask for a select value.
  function automatic logic [NCH-1:0] onehot(input logic [SELW-1:0] s);
    logic [NCH-1:0] m;
    m    = '0;
    m[s] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/mux_rr_sequencer_if.sv
// Bundle of request, mux and downstream handshake signals around the sequencer.
// The master side is the sequencer itself; the slave side is its environment.
interface mux_rr_sequencer_if #(
  parameter int DW = 4
);
  import mux_seq_pkg::*;

  logic [NCH-1:0]  req;
  logic [DW-1:0]   mux_y;
  logic            out_ready;
  logic [SELW-1:0] sel;
  logic [NCH-1:0]  grant;
  logic            out_valid;
  logic [DW-1:0]   dout;
  logic [NCH-1:0]  ack;
  logic            busy;

  modport master (
    input  req, mux_y, out_ready,
    output sel, grant, out_valid, dout, ack, busy
  );

  modport slave (
    output req, mux_y, out_ready,
    input  sel, grant, out_valid, dout, ack, busy
  );

endinterface

// File: rtl/mux_rr_sequencer_rr_pick.sv
// Round-robin arbiter core: finds the first requesting channel after last_ptr.
// Works by rotating the request vector so the search starts at bit 0,
// priority-encoding the lowest set bit, then adding the rotation back.
module rr_pick
  import mux_seq_pkg::*;
(
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] last_ptr,
  output logic [SELW-1:0] pick,
  output logic            any
);

  logic [SELW-1:0] start;
  logic [NCH-1:0]  rot;
  logic [SELW-1:0] idx;

  // Rotate, priority-encode and un-rotate; the 3-bit adds wrap 7->0 naturally.
  always_comb begin
    start = last_ptr + SELW'(1);
    rot   = '0;
    for (int i = 0; i < NCH; i++) begin
      rot[i] = req[SELW'(start + SELW'(i))];
    end
    idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (rot[i]) begin
        idx = SELW'(i);
      end
    end
    pick = start + idx;
    any  = |req;
  end

endmodule

// File: rtl/mux_rr_sequencer.sv
// Upstream control stage for an 8:1 mux: arbitrates channel requests
// round-robin, holds the select for a settle window, captures the mux output
// and presents it downstream on a valid/ready handshake, then acks the channel.
module mux_rr_sequencer
  import mux_seq_pkg::*;
#(
  parameter int DW         = 4,
  parameter int SETTLE_CYC = 2
)(
  input logic                clk,
  input logic                rst,
  mux_rr_sequencer_if.master bus
);

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYC - 1);

  state_t          state,    state_n;
  logic [3:0]      cnt,      cnt_n;
  logic [SELW-1:0] last_ptr, last_ptr_n;
  logic [SELW-1:0] sel_r,    sel_n;
  logic [NCH-1:0]  grant_r,  grant_n;
  logic            valid_r,  valid_n;
  logic [DW-1:0]   dout_r,   dout_n;
  logic [NCH-1:0]  ack_r,    ack_n;

  logic [SELW-1:0] pick;
  logic            any_req;

  rr_pick u_pick (
    .req      (bus.req),
    .last_ptr (last_ptr),
    .pick     (pick),
    .any      (any_req)
  );

  // Next-state and next-output logic; everything holds unless a transition says otherwise,
  // and ack drops back to zero every cycle so it can only ever be a single-cycle pulse.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    last_ptr_n = last_ptr;
    sel_n      = sel_r;
    grant_n    = grant_r;
    valid_n    = valid_r;
    dout_n     = dout_r;
    ack_n      = '0;

    case (state)
      IDLE: begin
        grant_n = '0;
        if (any_req) begin
          sel_n   = pick;
          grant_n = onehot(pick);
          cnt_n   = CNT_INIT;
          state_n = SETTLE;
        end
      end

      SETTLE: begin
        if (cnt != 4'd0) begin
          cnt_n = cnt - 4'd1;
        end else begin
          dout_n  = bus.mux_y;
          valid_n = 1'b1;
          state_n = PRESENT;
        end
      end

      PRESENT: begin
        if (valid_r && bus.out_ready) begin
          valid_n    = 1'b0;
          ack_n      = grant_r;
          last_ptr_n = sel_r;
          grant_n    = '0;
          state_n    = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
        grant_n = '0;
        valid_n = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any word in flight and points the arbiter at channel 7
  // so that channel 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      last_ptr <= SELW'(NCH - 1);
      sel_r    <= '0;
      grant_r  <= '0;
      valid_r  <= 1'b0;
      dout_r   <= '0;
      ack_r    <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      last_ptr <= last_ptr_n;
      sel_r    <= sel_n;
      grant_r  <= grant_n;
      valid_r  <= valid_n;
      dout_r   <= dout_n;
      ack_r    <= ack_n;
    end
  end

  assign bus.sel       = sel_r;
  assign bus.grant     = grant_r;
  assign bus.out_valid = valid_r;
  assign bus.dout      = dout_r;
  assign bus.ack       = ack_r;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_mux_rr_sequencer.sv
// Self-checking bench for mux_rr_sequencer: a behavioural 8:1 mux feeds the DUT,
// a driver issues words and queues the expected channel/data, and a monitor
// compares every presented word and every ack against that queue.
module tb_mux_rr_sequencer;
  import mux_seq_pkg::*;

  localparam int DW         = 4;
  localparam int SETTLE_CYC = 2;

  typedef struct {
    int            chan;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [DW-1:0] ch [NCH];
  exp_t          sb [$];

  int tests = 0;
  int fails = 0;

  int lastPtr  = NCH - 1;
  int modelSel = 0;

  logic [NCH-1:0] pendingAck = '0;
  bit             ackDue     = 1'b0;

  mux_rr_sequencer_if #(.DW(DW)) bus ();

  mux_rr_sequencer #(
    .DW         (DW),
    .SETTLE_CYC (SETTLE_CYC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Behavioural 8:1 mux driven by the DUT select.
  always_comb bus.mux_y = ch[bus.sel];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Round-robin rule: first requesting channel after the last served one, wrapping 7->0.
  function automatic int modelPick(input logic [NCH-1:0] r, input int last);
    for (int k = 1; k <= NCH; k++) begin
      int c;
      c = (last + k) % NCH;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  // Monitor: checks presented words against the scoreboard and the ack pulse that follows.
  always @(negedge clk) begin
    if (rst) begin
      ackDue = 1'b0;
    end else begin
      if (ackDue) begin
        checkOutput("ack_pulse", bus.ack, pendingAck);
        checkOutput("valid_drop", bus.out_valid, 1'b0);
        ackDue = 1'b0;
      end else begin
        checkOutput("ack_quiet", bus.ack, '0);
      end
      if (bus.out_valid) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_word: got dout %0h, expected no word at %0t", bus.dout, $time);
        end else begin
          checkOutput("dout", bus.dout, sb[0].data);
          checkOutput("sel_hold", bus.sel, sb[0].chan);
          checkOutput("grant_hold", bus.grant, onehot(SELW'(sb[0].chan)));
          checkOutput("busy_present", bus.busy, 1'b1);
          if (bus.out_ready) begin
            pendingAck = onehot(SELW'(sb[0].chan));
            ackDue     = 1'b1;
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  task automatic resetPhase();
    bus.req = 8'hFF;
    rst     = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      checkOutput("rst_sel", bus.sel, '0);
      checkOutput("rst_grant", bus.grant, '0);
      checkOutput("rst_valid", bus.out_valid, 1'b0);
      checkOutput("rst_dout", bus.dout, '0);
      checkOutput("rst_ack", bus.ack, '0);
      checkOutput("rst_busy", bus.busy, 1'b0);
    end
    rst = 1'b0;
    sb.delete();
    lastPtr  = NCH - 1;
    modelSel = 0;
  endtask

  // Issue one request pattern and walk the word through settle, optional stall and handshake.
  task automatic applyStimulus(input logic [NCH-1:0] r, input bit dropReq, input int stall, input bit newData);
    int c;
    c = modelPick(r, lastPtr);
    bus.req = r;
    sb.push_back('{chan: c, data: ch[c]});
    lastPtr = c;
    @(posedge clk); #1;
    checkOutput("grant_sel", bus.sel, c);
    checkOutput("grant_onehot", bus.grant, onehot(SELW'(c)));
    checkOutput("busy_settle", bus.busy, 1'b1);
    if (dropReq) bus.req = '0;
    bus.out_ready = 1'($urandom % 2);
    for (int k = 1; k <= SETTLE_CYC; k++) begin
      @(posedge clk); #1;
      checkOutput("settle_len", bus.out_valid, (k == SETTLE_CYC));
    end
    bus.out_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      if (newData) ch[c] = ch[c] ^ 4'b1011;
      @(posedge clk); #1;
      checkOutput("stall_valid", bus.out_valid, 1'b1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("hs_valid", bus.out_valid, 1'b0);
    checkOutput("hs_busy", bus.busy, 1'b0);
    modelSel = c;
  endtask

  task automatic idleCycles(input int n);
    bus.req = '0;
    repeat (n) begin
      @(posedge clk); #1;
      checkOutput("idle_grant", bus.grant, '0);
      checkOutput("idle_busy", bus.busy, 1'b0);
      checkOutput("idle_sel", bus.sel, modelSel);
    end
  endtask

  // Start a word for channel 5, then reset it in SETTLE or PRESENT and confirm channel 0 wins next.
  task automatic abortTest(input bit inPresent);
    int c;
    applyStimulus(8'h40, 1'b0, 0, 1'b0);
    c = modelPick(8'h20, lastPtr);
    bus.req = 8'h20;
    sb.push_back('{chan: c, data: ch[c]});
    @(posedge clk); #1;
    checkOutput("abort_grant", bus.grant, onehot(SELW'(c)));
    bus.out_ready = 1'b0;
    if (inPresent) begin
      repeat (SETTLE_CYC) begin
        @(posedge clk); #1;
      end
      checkOutput("abort_in_present", bus.out_valid, 1'b1);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("abort_valid", bus.out_valid, 1'b0);
    checkOutput("abort_ack", bus.ack, '0);
    checkOutput("abort_grant_clr", bus.grant, '0);
    checkOutput("abort_busy", bus.busy, 1'b0);
    rst = 1'b0;
    sb.delete();
    lastPtr  = NCH - 1;
    modelSel = 0;
    applyStimulus(8'h81, 1'b0, 0, 1'b0);
  endtask

  // Directed scenarios followed by randomized traffic, then the summary.
  initial begin
    bus.req       = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < NCH; i++) ch[i] = DW'(i);

    resetPhase();
    applyStimulus(8'hFF, 1'b0, 0, 1'b0);

    ch[3] = 4'b0001;
    applyStimulus(8'h08, 1'b0, 0, 1'b0);
    applyStimulus(8'h05, 1'b0, 0, 1'b0);
    applyStimulus(8'h05, 1'b1, 0, 1'b0);

    resetPhase();
    for (int i = 0; i < NCH; i++) ch[i] = DW'(i);
    for (int w = 0; w <= NCH; w++) applyStimulus(8'hFF, 1'b0, 0, 1'b0);

    ch[4] = 4'b1000;
    applyStimulus(8'h10, 1'b0, 5, 1'b1);
    idleCycles(3);

    abortTest(1'b1);
    abortTest(1'b0);

    for (int w = 0; w < 150; w++) begin
      for (int i = 0; i < NCH; i++) ch[i] = DW'($urandom);
      applyStimulus(NCH'($urandom_range(1, 255)), 1'($urandom % 2), $urandom_range(0, 3), 1'($urandom % 2));
      if ($urandom % 4 == 0) idleCycles($urandom_range(1, 3));
    end

    bus.req = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog so a stuck run still ends with a visible failure.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
